// File: rtl/au_acc_csv.sv
// au_acc_csv: sequential multi-operand accumulator.
// Operands are folded into a redundant sum/carry pair with a 3:2 compressor,
// so accumulation never waits on a carry chain. At end of frame the pair is
// resolved CHUNK bits per cycle by a digit-serial carry-propagate adder.
// ACC_WIDTH must be a multiple of CHUNK, and WIDTH <= ACC_WIDTH.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid & ready are both 1. A source holding valid must keep its data stable
// until that edge; ready never depends combinationally on valid.
module au_acc_csv #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CHUNK     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic [CNT_WIDTH-1:0] out_cnt,
    output logic [1:0]           o_dbg_state
);

    localparam int N     = ACC_WIDTH / CHUNK;
    // The index runs 0..N: N chunk cycles plus one finalisation cycle.
    localparam int IDX_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [ACC_WIDTH-1:0]   r_s;
    logic [ACC_WIDTH-1:0]   r_c;
    logic                   r_sticky;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic [ACC_WIDTH-1:0]   r_res;
    logic [ACC_WIDTH-1:0]   r_out_data;
    logic                   r_out_ovf;
    logic [CNT_WIDTH-1:0]   r_out_cnt;

    logic                   w_accept;
    logic                   w_res_done;
    logic [ACC_WIDTH-1:0]   w_x;
    logic [ACC_WIDTH-1:0]   w_c_sh;
    logic [ACC_WIDTH-1:0]   w_s_nxt;
    logic [ACC_WIDTH-1:0]   w_c_nxt;
    logic [CHUNK-1:0]       w_s_chunk;
    logic [CHUNK-1:0]       w_c_chunk;
    logic [CHUNK:0]         w_sum;
    logic                   w_ovf_final;

    assign w_accept   = in_valid & in_ready;
    assign w_res_done = (r_state == ST_RES) && (r_idx == IDX_W'(N));

    // 3:2 compression of S, C<<1 and the zero-extended operand.
    assign w_x     = ACC_WIDTH'(in_data);
    assign w_c_sh  = r_c << 1;
    assign w_s_nxt = r_s ^ w_c_sh ^ w_x;
    assign w_c_nxt = (r_s & w_c_sh) | (r_s & w_x) | (w_c_sh & w_x);

    // Chunk adder for the digit-serial resolve; the carry is registered.
    assign w_sum = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + {{CHUNK{1'b0}}, r_carry};

    // The final carry-out and the top bit of C (lost by the <<1 during
    // resolve) are both weight 2^ACC_WIDTH, so either one means overflow.
    assign w_ovf_final = r_sticky | r_carry | r_c[ACC_WIDTH-1];

    assign out_data    = r_out_data;
    assign out_ovf     = r_out_ovf;
    assign out_cnt     = r_out_cnt;
    assign o_dbg_state = r_state;

    // Select chunk r_idx of S and C<<1 (zero once the index reaches N).
    always_comb begin
        w_s_chunk = '0;
        w_c_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_s_chunk = r_s[k*CHUNK +: CHUNK];
                w_c_chunk = w_c_sh[k*CHUNK +: CHUNK];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_next = ST_RES;
                end
            end
            ST_RES: begin
                if (w_res_done) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_ACC;
                end
            end
            default: begin
                w_next = ST_ACC;
            end
        endcase
    end

    // Accumulate, resolve chunk by chunk, capture the result, clear on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s        <= '0;
            r_c        <= '0;
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_res      <= '0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
            r_out_cnt  <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_s      <= w_s_nxt;
                        r_c      <= w_c_nxt;
                        r_sticky <= r_sticky | r_c[ACC_WIDTH-1];
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_RES: begin
                    if (w_res_done) begin
                        r_sticky   <= w_ovf_final;
                        r_out_data <= r_res;
                        r_out_ovf  <= w_ovf_final;
                        r_out_cnt  <= r_cnt;
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_res[k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
                            end
                        end
                        r_carry <= w_sum[CHUNK];
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_s      <= '0;
                        r_c      <= '0;
                        r_sticky <= 1'b0;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_res    <= '0;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_au_acc_csv.sv
// Testbench for au_acc_csv: default instance (16-bit, CHUNK=4) and a
// narrow instance (8-bit, CHUNK=1). Expected results are pushed when a frame
// is issued; per-instance monitors pop and compare when out_valid appears.
`timescale 1ns/1ps
module tb_au_acc_csv;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default instance
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [7:0]  in_data, out_cnt;
    logic [15:0] out_data;
    logic [1:0]  dbg_state;

    // narrow instance
    logic        in1_valid, in1_ready, in1_last, out1_valid, out1_ready, out1_ovf;
    logic [7:0]  in1_data, out1_cnt, out1_data;
    logic [1:0]  dbg1_state;

    au_acc_csv dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_cnt(out_cnt), .o_dbg_state(dbg_state)
    );

    au_acc_csv #(.WIDTH(8), .ACC_WIDTH(8), .CHUNK(1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data), .in_last(in1_last),
        .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
        .out_ovf(out1_ovf), .out_cnt(out1_cnt), .o_dbg_state(dbg1_state)
    );

    // ---------------- scoreboard ----------------
    // default: {lat[7:0], cnt[7:0], ovf, data[15:0]}
    logic [32:0] exp_q[$];
    // narrow:  {lat[7:0], cnt[7:0], ovf, data[7:0]}
    logic [24:0] exp1_q[$];
    int n_cmp = 0;
    int n_err = 0;
    time last_acc_t  = 0;
    time last_acc1_t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] pk(input int lat, input int cnt, input bit ovf, input int data);
        return {lat[7:0], cnt[7:0], ovf, data[15:0]};
    endfunction

    function automatic logic [24:0] pk1(input int lat, input int cnt, input bit ovf, input int data);
        return {lat[7:0], cnt[7:0], ovf, data[7:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] d, input bit l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        last_acc_t = $time;
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input bit l);
        int t = 0;
        in1_valid = 1'b1;
        in1_data  = d;
        in1_last  = l;
        @(negedge clk);
        while (!in1_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in1_ready) chk("send1_timeout", 32'(in1_ready), 32'd1);
        @(posedge clk);
        last_acc1_t = $time;
        #1;
        in1_valid = 1'b0;
        in1_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0 || out_valid || out1_valid) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 400) chk("drain_timeout", 32'(exp_q.size() + exp1_q.size()), 32'd0);
    endtask

    // ---------------- monitor: default instance ----------------
    logic        prev_v = 1'b0;
    logic [15:0] h_data;
    logic        h_ovf;
    logic [7:0]  h_cnt;
    logic [32:0] e;
    int          lat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else if (out_valid) begin
            if (!prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    lat = int'(($time - last_acc_t - 64'd5) / 64'd10);
                    chk("out_data", 32'(out_data), 32'(e[15:0]));
                    chk("out_ovf", 32'(out_ovf), 32'(e[16]));
                    chk("out_cnt", 32'(out_cnt), 32'(e[24:17]));
                    chk("latency", 32'(lat), 32'(e[32:25]));
                end
                h_data = out_data;
                h_ovf  = out_ovf;
                h_cnt  = out_cnt;
            end else begin
                chk("hold_data", 32'(out_data), 32'(h_data));
                chk("hold_ovf", 32'(out_ovf), 32'(h_ovf));
                chk("hold_cnt", 32'(out_cnt), 32'(h_cnt));
            end
            chk("in_ready_in_out", 32'(in_ready), 32'd0);
            prev_v = !out_ready;
        end else begin
            prev_v = 1'b0;
        end
    end

    // ---------------- monitor: narrow instance ----------------
    logic        prev1_v = 1'b0;
    logic [24:0] e1;
    int          lat1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev1_v = 1'b0;
        end else if (out1_valid) begin
            if (!prev1_v) begin
                if (exp1_q.size() == 0) begin
                    chk("unexpected_out1", 32'(out1_valid), 32'd0);
                end else begin
                    e1 = exp1_q.pop_front();
                    lat1 = int'(($time - last_acc1_t - 64'd5) / 64'd10);
                    chk("out1_data", 32'(out1_data), 32'(e1[7:0]));
                    chk("out1_ovf", 32'(out1_ovf), 32'(e1[8]));
                    chk("out1_cnt", 32'(out1_cnt), 32'(e1[16:9]));
                    chk("latency1", 32'(lat1), 32'(e1[24:17]));
                end
            end
            prev1_v = !out1_ready;
        end else begin
            prev1_v = 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rst_n      = 1'b0;
        in_valid   = 1'b0; in_data  = '0; in_last  = 1'b0; out_ready  = 1'b1;
        in1_valid  = 1'b0; in1_data = '0; in1_last = 1'b0; out1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // reset values
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_in1_ready", 32'(in1_ready), 32'd1);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // three 0xFF back-to-back: 765 = 0x02FD
        exp_q.push_back(pk(5, 3, 1'b0, 16'h02FD));
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        wait_drain();

        // single operand frame; in_ready low until the output handshake
        exp_q.push_back(pk(5, 1, 1'b0, 16'h0080));
        send(8'h80, 1'b1);
        t = 0;
        while (t < 20) begin
            @(negedge clk);
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) break;
            t++;
        end
        if (t >= 20) chk("single_timeout", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // 258 x 0xFF = 0x100FE: wraps to 0x00FE, overflow, count saturated
        exp_q.push_back(pk(5, 255, 1'b1, 16'h00FE));
        for (int i = 0; i < 258; i++) send(8'hFF, i == 257);
        wait_drain();

        // output stall: out_ready low, in_valid pulses must be ignored
        out_ready = 1'b0;
        exp_q.push_back(pk(5, 1, 1'b0, 16'h0012));
        send(8'h12, 1'b1);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid) chk("stall_wait_timeout", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            in_data  = 8'hAA;
            in_last  = 1'b1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        // next frame starts from cleared state
        exp_q.push_back(pk(5, 2, 1'b0, 16'h0003));
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        wait_drain();

        // reset in the middle of resolve aborts the frame
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        chk("abort_out_ovf", 32'(out_ovf), 32'd0);
        chk("abort_out_cnt", 32'(out_cnt), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_output", 32'(out_valid), 32'd0);
        exp_q.push_back(pk(5, 1, 1'b0, 16'h0005));
        send(8'h05, 1'b1);
        wait_drain();

        // narrow instance: CHUNK=1, carry ripples across all 8 chunks
        exp1_q.push_back(pk1(9, 2, 1'b1, 8'h00));
        send1(8'hFF, 1'b0);
        send1(8'h01, 1'b1);
        wait_drain();
        exp1_q.push_back(pk1(9, 2, 1'b0, 8'h80));
        send1(8'h7F, 1'b0);
        send1(8'h01, 1'b1);
        wait_drain();

        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("exp1_q_empty", 32'(exp1_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
